sm_frame_accum: RTL and testbench

- Sequential accumulator directly downstream of the team's sign-magnitude add/sub datapath.
- Consumes a stream of DW-bit sign-magnitude samples over a valid/ready handshake.
- Adds or subtracts each sample into a running sum. After LEN samples, emits one saturated sign-magnitude frame result over a second valid/ready handshake.
- Operand format matches the add/sub block: bit DW-1 is the sign (1 = negative), bits DW-2:0 are the magnitude.

---
 rtl/sm_frame_accum.sv | 126 ++++++++++++
 tb/tb_sm_frame_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sm_frame_accum.sv
// sm_frame_accum: frame accumulator for sign-magnitude samples.
// Each accepted sample is converted to two's complement and added into a
// widened accumulator. After LEN samples the block presents one saturated
// sign-magnitude result and holds it until the downstream handshake.
module sm_frame_accum #(
    parameter int DW  = 16,
    parameter int LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sat
);

    // Guard bits let LEN full-scale samples sum without wrapping.
    localparam int AW = DW + $clog2(LEN);
    localparam int CW = $clog2(LEN + 1);

    localparam logic [AW-1:0] MAX_MAG  = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_outData;
    logic          r_outSat;

    logic          w_accept;
    logic          w_last;
    logic          w_neg;
    logic [AW-1:0] w_mag;
    logic [AW-1:0] w_sample;
    logic [AW-1:0] w_accNext;
    logic [AW-1:0] w_accAbs;
    logic          w_clip;
    logic [DW-2:0] w_resultMag;

    // Negative zero becomes plain zero because negating zero yields zero.
    assign w_mag     = {{(AW - DW + 1){1'b0}}, in_data[DW-2:0]};
    assign w_neg     = in_data[DW-1] ^ in_sub;
    assign w_sample  = w_neg ? (~w_mag + 1'b1) : w_mag;
    assign w_accNext = r_acc + w_sample;

    // The frame result is taken from the sum that includes the final sample.
    // A zero sum has a clear sign bit, so negative zero is never emitted.
    assign w_accAbs    = w_accNext[AW-1] ? (~w_accNext + 1'b1) : w_accNext;
    assign w_clip      = (w_accAbs > MAX_MAG);
    assign w_resultMag = w_clip ? MAX_MAG[DW-2:0] : w_accAbs[DW-2:0];

    // clr drops any sample offered in the same cycle.
    assign w_accept = (r_state == ST_ACC) && in_valid && !clr;
    assign w_last   = w_accept && (r_cnt == LAST_CNT);

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_outData;
    assign out_sat   = r_outSat;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: collect LEN samples, then hold until taken; clr aborts.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_last) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_nextState = ST_ACC;
                end
            end
            default: w_nextState = ST_ACC;
        endcase
        if (clr) begin
            w_nextState = ST_ACC;
        end
    end

    // Accumulator, sample counter and registered frame result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_outData <= '0;
            r_outSat  <= 1'b0;
        end else if (clr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_outSat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_outData <= {w_accNext[AW-1], w_resultMag};
                r_outSat  <= w_clip;
            end
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sm_frame_accum.sv
// tb_sm_frame_accum: directed and randomized checks of sm_frame_accum
// against a queue-based frame model plus literal expected results.
module tb_sm_frame_accum;

    localparam int DW  = 16;
    localparam int LEN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    sm_frame_accum #(.DW(DW), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Behavioural model: list of signed sample values in the current frame.
    int            frameQ[$];
    logic          mHold;
    logic [DW-1:0] mData;
    logic          mSat;

    function automatic int toInt(input logic [DW-1:0] d, input logic sub);
        int m;
        m = int'(d[DW-2:0]);
        return (d[DW-1] ^ sub) ? -m : m;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge; async reset mirrors the port behaviour.
    always @(posedge clk or posedge rst) begin : model
        int s;
        int mag;
        if (rst) begin
            frameQ.delete();
            mHold <= 1'b0;
            mData <= '0;
            mSat  <= 1'b0;
        end else if (clr) begin
            frameQ.delete();
            mHold <= 1'b0;
            mSat  <= 1'b0;
        end else if (!mHold) begin
            if (in_valid) begin
                frameQ.push_back(toInt(in_data, in_sub));
                if (frameQ.size() == LEN) begin
                    s = 0;
                    foreach (frameQ[k]) s += frameQ[k];
                    frameQ.delete();
                    mag = (s < 0) ? -s : s;
                    mSat <= (mag > 32767);
                    if (mag > 32767) mag = 32767;
                    mData <= {(s < 0) ? 1'b1 : 1'b0, mag[DW-2:0]};
                    mHold <= 1'b1;
                end
            end
        end else if (out_ready) begin
            mHold <= 1'b0;
        end
    end

    // Compare process: outputs checked against the model away from the active edge.
    always @(negedge clk) begin
        if (compareOn && !rst) begin
            checkOutput("cmp_in_ready", 32'(in_ready), 32'(!mHold));
            checkOutput("cmp_out_valid", 32'(out_valid), 32'(mHold));
            checkOutput("cmp_out_data", 32'(out_data), 32'(mData));
            if (mHold) checkOutput("cmp_out_sat", 32'(out_sat), 32'(mSat));
        end
    end

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic s,
                                 input logic rdy, input logic c);
        in_valid  = v;
        in_data   = d;
        in_sub    = s;
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send LEN back-to-back samples and check the literal frame result.
    task automatic runFrame(input string name, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic sub,
                            input logic [DW-1:0] expData, input logic expSat, input bit take);
        applyStimulus(1'b1, d0, sub, 1'b0, 1'b0);
        applyStimulus(1'b1, d1, sub, 1'b0, 1'b0);
        applyStimulus(1'b1, d2, sub, 1'b0, 1'b0);
        applyStimulus(1'b1, d3, sub, 1'b0, 1'b0);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_data"}, 32'(out_data), 32'(expData));
        checkOutput({name, "_sat"}, 32'(out_sat), 32'(expSat));
        if (take) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [DW-1:0] randSample();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0000);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        compareOn = 1'b1;

        runFrame("mixed_add", 16'h0064, 16'h00C8, 16'h8032, 16'h000A, 1'b0, 16'h0104, 1'b0, 1'b1);
        runFrame("sub_pos", 16'h0064, 16'h0064, 16'h0064, 16'h0064, 1'b1, 16'h8190, 1'b0, 1'b1);
        runFrame("sub_neg", 16'h8064, 16'h8064, 16'h8064, 16'h8064, 1'b1, 16'h0190, 1'b0, 1'b1);
        runFrame("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        runFrame("sat_neg", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        runFrame("cancel", 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1);
        runFrame("neg_zero", 16'h0005, 16'h8005, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Backpressure in HOLD: offered samples must not be absorbed.
        runFrame("bp_frame", 16'h0003, 16'h0003, 16'h0003, 16'h0003, 1'b0, 16'h000C, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_data_stable", 32'(out_data), 32'h000C);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        runFrame("bp_next", 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b1);

        // clr drops the sample offered in its own cycle.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);
        runFrame("clr_acc", 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0);

        // clr in HOLD discards the result even with out_ready high.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_hold_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_hold_ready", 32'(in_ready), 32'd1);
        runFrame("after_clr", 16'h0002, 16'h0002, 16'h0002, 16'h8001, 1'b0, 16'h0005, 1'b0, 1'b0);

        // Asynchronous reset mid-HOLD takes effect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_out_data", 32'(out_data), 32'h0000);
        checkOutput("async_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Randomized traffic with gaps, backpressure and occasional clr.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, randSample(), 1'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        compareOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
